offchip_mem_ctrl: RTL and testbench

- Responder end of the cache-line off-chip memory channel driven by the cache/memory controller under the system bus.
- Accepts whole-line read/write requests and serialises them into 32-bit word beats on a narrow external memory port with a req/ack handshake.
- Returns the assembled line with a one-cycle ready pulse.
- Exposes read/write busy flags and a timeout error.

---
 rtl/offchip_mem_ctrl_pkg.sv | 26 ++
 rtl/offchip_mem_ctrl_if.sv | 58 +++++
 rtl/offchip_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_offchip_mem_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/offchip_mem_ctrl_pkg.sv
// Shared configuration for the off-chip line memory channel:
// line geometry, beat-counter width and controller state encodings.
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 32
`endif

package offchip_mem_ctrl_pkg;

   localparam int LINE_BYTES     = `CACHE_LINE_SIZE;
   localparam int LINE_W         = LINE_BYTES * 8;
   localparam int WORDS_PER_LINE = LINE_BYTES / 4;
   localparam int BEAT_W         = (WORDS_PER_LINE > 1) ?
                                   $clog2(WORDS_PER_LINE) : 1;

   typedef enum logic [1:0] {
      OMC_IDLE,
      OMC_RD,
      OMC_WR,
      OMC_DONE
   } omc_state_e;

   function automatic logic [31:0] line_base(input logic [31:0] a);
      return a & ~32'(LINE_BYTES - 1);
   endfunction

endpackage

// File: rtl/offchip_mem_ctrl_if.sv
// Line request side and narrow external beat port of the
// off-chip memory controller, bundled with requester/responder views.
interface offchip_mem_ctrl_if;
   import offchip_mem_ctrl_pkg::*;

   logic              offchip_mem_read_en;
   logic              offchip_mem_write_en;
   logic [31:0]       offchip_mem_addr;
   logic [LINE_W-1:0] offchip_mem_wdata;
   logic [LINE_W-1:0] offchip_mem_data;
   logic              offchip_mem_ready;
   logic              offchip_mem_read_busy;
   logic              offchip_mem_write_busy;
   logic              offchip_mem_error;
   logic              ext_req;
   logic              ext_we;
   logic [31:0]       ext_addr;
   logic [31:0]       ext_wdata;
   logic [31:0]       ext_rdata;
   logic              ext_ack;

   modport slave (
      input  offchip_mem_read_en,
      input  offchip_mem_write_en,
      input  offchip_mem_addr,
      input  offchip_mem_wdata,
      output offchip_mem_data,
      output offchip_mem_ready,
      output offchip_mem_read_busy,
      output offchip_mem_write_busy,
      output offchip_mem_error,
      output ext_req,
      output ext_we,
      output ext_addr,
      output ext_wdata,
      input  ext_rdata,
      input  ext_ack
   );

   modport master (
      output offchip_mem_read_en,
      output offchip_mem_write_en,
      output offchip_mem_addr,
      output offchip_mem_wdata,
      input  offchip_mem_data,
      input  offchip_mem_ready,
      input  offchip_mem_read_busy,
      input  offchip_mem_write_busy,
      input  offchip_mem_error,
      input  ext_req,
      input  ext_we,
      input  ext_addr,
      input  ext_wdata,
      output ext_rdata,
      output ext_ack
   );

endinterface

// File: rtl/offchip_mem_ctrl.sv
// Serialises whole cache-line reads/writes into 32-bit beats on a
// req/ack external port; returns the line with a one-cycle ready pulse.
module offchip_mem_ctrl
   import offchip_mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   offchip_mem_ctrl_if.slave mem_io
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   omc_state_e        state_q, state_d;
   logic              wr_q, wr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [31:0]       base_q, base_d;
   logic [LINE_W-1:0] wbuf_q, wbuf_d;
   logic [LINE_W-1:0] rbuf_q, rbuf_d;
   logic              err_q, err_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic              req;
   logic              we;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              last;

   assign last = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OMC_IDLE;
         wr_q    <= 1'b0;
         beat_q  <= '0;
         base_q  <= '0;
         wbuf_q  <= '0;
         rbuf_q  <= '0;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         wbuf_q  <= wbuf_d;
         rbuf_q  <= rbuf_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      beat_d  = beat_q;
      base_d  = base_q;
      wbuf_d  = wbuf_q;
      rbuf_d  = rbuf_q;
      err_d   = err_q;
      wait_d  = wait_q;
      req     = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      unique case (state_q)
         OMC_IDLE: begin
            // Write wins a tie; a held read is picked up after DONE.
            if (mem_io.offchip_mem_write_en) begin
               base_d  = line_base(mem_io.offchip_mem_addr);
               wbuf_d  = mem_io.offchip_mem_wdata;
               err_d   = 1'b0;
               wr_d    = 1'b1;
               beat_d  = '0;
               wait_d  = '0;
               state_d = OMC_WR;
            end else if (mem_io.offchip_mem_read_en) begin
               base_d  = line_base(mem_io.offchip_mem_addr);
               err_d   = 1'b0;
               wr_d    = 1'b0;
               beat_d  = '0;
               wait_d  = '0;
               state_d = OMC_RD;
            end
         end
         OMC_RD, OMC_WR: begin
            req   = 1'b1;
            we    = (state_q == OMC_WR);
            addr  = base_q + 32'({beat_q, 2'b00});
            wdata = wbuf_q[int'(beat_q)*32 +: 32];
            if (mem_io.ext_ack) begin
               if (state_q == OMC_RD)
                  rbuf_d[int'(beat_q)*32 +: 32] = mem_io.ext_rdata;
               wait_d = '0;
               if (last) begin
                  beat_d  = '0;
                  state_d = OMC_DONE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end else if (TIMEOUT > 0) begin
               // The stall that reaches TIMEOUT aborts the line.
               if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  wait_d  = '0;
                  beat_d  = '0;
                  state_d = OMC_DONE;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         OMC_DONE: state_d = OMC_IDLE;
         default:  state_d = OMC_IDLE;
      endcase
   end

   assign mem_io.ext_req   = req;
   assign mem_io.ext_we    = we;
   assign mem_io.ext_addr  = addr;
   assign mem_io.ext_wdata = wdata;

   assign mem_io.offchip_mem_data       = rbuf_q;
   assign mem_io.offchip_mem_ready      = (state_q == OMC_DONE);
   assign mem_io.offchip_mem_error      = err_q;
   assign mem_io.offchip_mem_read_busy  = (state_q == OMC_RD) ||
                                          (state_q == OMC_DONE && !wr_q);
   assign mem_io.offchip_mem_write_busy = (state_q == OMC_WR) ||
                                          (state_q == OMC_DONE && wr_q);

endmodule

// File: tb/tb_offchip_mem_ctrl.sv
// Bench for offchip_mem_ctrl: vector table plus corner sequences,
// with beat and line scoreboards fed at stimulus time.
module tb_offchip_mem_ctrl;
   import offchip_mem_ctrl_pkg::*;

   localparam int N = WORDS_PER_LINE;

   logic clk = 1'b0;
   logic rst = 1'b1;

   offchip_mem_ctrl_if mif();

   offchip_mem_ctrl #(.TIMEOUT(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .mem_io (mif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic [LINE_W-1:0] data;
      logic              err;
      logic              chk_data;
   } res_t;

   typedef struct {
      logic              wr;
      logic [31:0]       addr;
      logic [LINE_W-1:0] wdata;
      logic [31:0]       seed;
      int                sa;
      int                sb;
      int                sl;
      int                lat;
   } vec_t;

   beat_t exp_beats[$];
   res_t  exp_res[$];

   int checks = 0;
   int errors = 0;

   int          beat_seen = 0;
   int          stall_cnt = 0;
   int          stall_a   = -1;
   int          stall_b   = -1;
   int          stall_len = 0;
   bit          hold0     = 1'b0;
   logic [31:0] rd_seed   = '0;

   logic [LINE_W-1:0] model_line = '0;

   task automatic chk32(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chkline(input string nm,
                          input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // External memory model: ack/stall control and beat scoreboard.
   always @(negedge clk) begin
      beat_t b;
      if (hold0)
         mif.ext_ack = 1'b0;
      else if (mif.ext_req &&
               (beat_seen == stall_a || beat_seen == stall_b) &&
               stall_cnt < stall_len) begin
         mif.ext_ack = 1'b0;
         stall_cnt++;
      end else
         mif.ext_ack = 1'b1;
      mif.ext_rdata = rd_seed + ((mif.ext_addr >> 2) & 32'(N - 1));
      if (mif.ext_req) begin
         if (exp_beats.size() == 0) begin
            if (mif.ext_ack) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat addr %h", mif.ext_addr);
            end
         end else if (mif.ext_ack) begin
            b = exp_beats.pop_front();
            chk32("beat_addr", mif.ext_addr, b.addr);
            chk32("beat_we", 32'(mif.ext_we), 32'(b.we));
            if (b.we)
               chk32("beat_wdata", mif.ext_wdata, b.wdata);
            beat_seen++;
            stall_cnt = 0;
         end else begin
            b = exp_beats[0];
            chk32("stall_addr", mif.ext_addr, b.addr);
            if (b.we)
               chk32("stall_wdata", mif.ext_wdata, b.wdata);
         end
      end
   end

   task automatic push_beats(input logic wr,
                             input logic [31:0] a,
                             input logic [LINE_W-1:0] wd);
      logic [31:0] base;
      base = a & ~32'(LINE_BYTES - 1);
      for (int i = 0; i < N; i++)
         exp_beats.push_back('{base + 32'(4*i), wr, wd[32*i +: 32]});
   endtask

   function automatic logic [LINE_W-1:0] rd_line(input logic [31:0] s);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < N; i++)
         l[32*i +: 32] = s + 32'(i);
      return l;
   endfunction

   task automatic wait_ready(input bit wr, input int max,
                             output int lat);
      res_t r;
      bit   done;
      lat  = 0;
      done = 1'b0;
      while (!done && lat < max) begin
         @(negedge clk);
         #1;
         lat++;
         if (mif.ext_req || mif.offchip_mem_ready) begin
            chk32("read_busy", 32'(mif.offchip_mem_read_busy), 32'(!wr));
            chk32("write_busy", 32'(mif.offchip_mem_write_busy), 32'(wr));
         end
         if (mif.offchip_mem_ready) begin
            done = 1'b1;
            if (wr) mif.offchip_mem_write_en = 1'b0;
            else    mif.offchip_mem_read_en  = 1'b0;
            chk32("req_in_done", 32'(mif.ext_req), 32'(0));
            if (exp_res.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready at %0d", lat);
            end else begin
               r = exp_res.pop_front();
               if (r.chk_data)
                  chkline("line_data", mif.offchip_mem_data, r.data);
               chk32("error", 32'(mif.offchip_mem_error), 32'(r.err));
            end
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got none want within %0d", max);
      end
      @(negedge clk);
      #1;
      chk32("ready_once", 32'(mif.offchip_mem_ready), 32'(0));
      chk32("idle_rbusy", 32'(mif.offchip_mem_read_busy), 32'(0));
      chk32("idle_wbusy", 32'(mif.offchip_mem_write_busy), 32'(0));
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      beat_seen = 0;
      stall_cnt = 0;
      stall_a   = v.sa;
      stall_b   = v.sb;
      stall_len = v.sl;
      rd_seed   = v.seed;
      push_beats(v.wr, v.addr, v.wdata);
      if (!v.wr)
         model_line = rd_line(v.seed);
      exp_res.push_back('{model_line, 1'b0, 1'b1});
      mif.offchip_mem_addr  = v.addr;
      mif.offchip_mem_wdata = v.wdata;
      if (v.wr) mif.offchip_mem_write_en = 1'b1;
      else      mif.offchip_mem_read_en  = 1'b1;
      wait_ready(v.wr, 40, lat);
      chk32("latency", 32'(lat), 32'(v.lat));
   endtask

   vec_t              vecs[5];
   logic [LINE_W-1:0] wl;
   logic [LINE_W-1:0] wl2;
   int                lat;

   initial begin
      mif.offchip_mem_read_en  = 1'b0;
      mif.offchip_mem_write_en = 1'b0;
      mif.offchip_mem_addr     = '0;
      mif.offchip_mem_wdata    = '0;

      for (int i = 0; i < N; i++) begin
         wl[32*i +: 32]  = 32'h1111_1111 * 32'(i);
         wl2[32*i +: 32] = 32'hC0DE_0000 ^ (32'(i) << 8) ^ 32'(i);
      end
      vecs[0] = '{1'b0, 32'h0000_1234, '0, 32'hA0,
                  -1, -1, 0, 9};
      vecs[1] = '{1'b1, 32'h0000_0080, wl, 32'h0,
                  -1, -1, 0, 9};
      vecs[2] = '{1'b0, 32'h0000_2000, '0, 32'h5000,
                  2, 5, 3, 15};
      vecs[3] = '{1'b1, 32'hFFFF_FFE5, wl2, 32'h0,
                  0, -1, 3, 12};
      vecs[4] = '{1'b0, 32'hFFFF_FFE0, '0, 32'h77,
                  -1, -1, 0, 9};

      repeat (2) @(negedge clk);
      #1;
      chkline("rst_data", mif.offchip_mem_data, '0);
      chk32("rst_ready", 32'(mif.offchip_mem_ready), 0);
      chk32("rst_rbusy", 32'(mif.offchip_mem_read_busy), 0);
      chk32("rst_wbusy", 32'(mif.offchip_mem_write_busy), 0);
      chk32("rst_error", 32'(mif.offchip_mem_error), 0);
      chk32("rst_req", 32'(mif.ext_req), 0);
      chk32("rst_we", 32'(mif.ext_we), 0);
      chk32("rst_addr", mif.ext_addr, 0);
      chk32("rst_wdata", mif.ext_wdata, 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++)
         run_vec(vecs[i]);

      // Simultaneous write and read on the same line.
      beat_seen = 0;
      stall_a   = -1;
      stall_b   = -1;
      stall_len = 0;
      rd_seed   = 32'h3300;
      push_beats(1'b1, 32'h40, wl);
      push_beats(1'b0, 32'h40, '0);
      exp_res.push_back('{model_line, 1'b0, 1'b1});
      model_line = rd_line(32'h3300);
      exp_res.push_back('{model_line, 1'b0, 1'b1});
      mif.offchip_mem_addr     = 32'h40;
      mif.offchip_mem_wdata    = wl;
      mif.offchip_mem_write_en = 1'b1;
      mif.offchip_mem_read_en  = 1'b1;
      wait_ready(1'b1, 40, lat);
      chk32("both_wr_lat", 32'(lat), 9);
      wait_ready(1'b0, 40, lat);
      chk32("both_rd_lat", 32'(lat), 9);

      // Reset while beat 4 of a read is on the port.
      beat_seen = 0;
      stall_cnt = 0;
      rd_seed   = 32'h900;
      push_beats(1'b0, 32'h500, '0);
      mif.offchip_mem_addr    = 32'h500;
      mif.offchip_mem_read_en = 1'b1;
      for (int i = 0; i < 20 && beat_seen < 5; i++) begin
         @(negedge clk);
         #1;
      end
      chk32("rst_mid_reached", 32'(beat_seen), 5);
      rst = 1'b1;
      mif.offchip_mem_read_en = 1'b0;
      @(negedge clk);
      #1;
      exp_beats.delete();
      chk32("rstmid_req", 32'(mif.ext_req), 0);
      chk32("rstmid_rbusy", 32'(mif.offchip_mem_read_busy), 0);
      chk32("rstmid_ready", 32'(mif.offchip_mem_ready), 0);
      chkline("rstmid_data", mif.offchip_mem_data, '0);
      rst = 1'b0;
      model_line = '0;
      run_vec('{1'b0, 32'h0000_0504, '0, 32'h1234_5600,
                -1, -1, 0, 9});

      // ext_ack held low: abort after TIMEOUT stalled cycles.
      hold0     = 1'b1;
      beat_seen = 0;
      exp_res.push_back('{'0, 1'b1, 1'b0});
      mif.offchip_mem_addr    = 32'h300;
      mif.offchip_mem_read_en = 1'b1;
      wait_ready(1'b0, 20, lat);
      chk32("to_lat", 32'(lat), 5);
      chk32("to_sticky", 32'(mif.offchip_mem_error), 1);
      hold0 = 1'b0;
      model_line = mif.offchip_mem_data;
      run_vec('{1'b0, 32'h0000_0340, '0, 32'hBEEF_0000,
                -1, -1, 0, 9});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
